// File: rtl/vga_text_renderer.sv
// vga_text_renderer: 80x30 text-mode pixel generator behind the 800x600 VGA timing generator
// Ports:
//   clk36m, reset_n            pixel clock, asynchronous active-low reset
//   col, row                   timing-generator counters (0..1023, 0..624)
//   hsync_in .. vblank_in      timing-generator strobes
//   vram_addr / vram_data      video RAM read port (data one cycle after address)
//   font_addr / font_data      8x16 font ROM read port (data one cycle after address)
//   cursor_x, cursor_y         cursor cell (only with VGA_TEXT_CURSOR_EN)
//   video_r/g/b                pixel colour, 5 cycles after col/row
//   hsync .. vblank            input strobes delayed by 5 cycles
// Build option: define VGA_TEXT_CURSOR_EN for a blinking underline cursor.
module vga_text_renderer #(
  parameter logic [17:0] FG_RGB = 18'h00FC0,
  parameter int TEXT_COLS = 80,
  parameter int TEXT_ROWS = 30
) (
  input  logic        clk36m,
  input  logic        reset_n,
  input  logic [10:0] col,
  input  logic [9:0]  row,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblank_in,
  input  logic        vblank_in,
  output logic [11:0] vram_addr,
  input  logic [7:0]  vram_data,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_data,
  input  logic [6:0]  cursor_x,
  input  logic [4:0]  cursor_y,
  output logic [5:0]  video_r,
  output logic [5:0]  video_g,
  output logic [5:0]  video_b,
  output logic        hsync,
  output logic        vsync,
  output logic        hblank,
  output logic        vblank
);
  localparam logic [10:0] ACT_W = 11'(TEXT_COLS * 10);
  localparam logic [9:0]  ACT_H = 10'(TEXT_ROWS * 20);
  localparam logic [11:0] LINE_STEP = 12'(TEXT_COLS);
  logic [3:0] px, px_n;
  logic [6:0] cx, cx_n;
  logic [4:0] ly, ly_n, cy, cy_n;
  logic [11:0] line_base, line_base_n;
  logic synced, synced_n, home, top, active, cur_vis, cur_hit, glyph, pix, inv3, inv4;
  // per-stage side info: {active, px[3:0], ly[4:0], cursor}
  logic [10:0] s1, s2, s3, s4;
  logic [4:0][3:0] dly;
  logic [17:0] rgb;
  // The *_n values describe the current col/row; the registers hold the previous cycle's.
  assign home = col == 11'd0;
  assign top = home && row == 10'd0;
  always_comb begin
    px_n = (home || px == 4'd9) ? 4'd0 : px + 4'd1;
    cx_n = home ? 7'd0 : px == 4'd9 ? cx + 7'd1 : cx;
    ly_n = !home ? ly : (row == 10'd0 || ly == 5'd19) ? 5'd0 : ly + 5'd1;
    cy_n = !home ? cy : row == 10'd0 ? 5'd0 : ly == 5'd19 ? cy + 5'd1 : cy;
    line_base_n = !home ? line_base : row == 10'd0 ? 12'd0 : ly == 5'd19 ? line_base + LINE_STEP : line_base;
    synced_n = synced | top;
    active = col < ACT_W && row < ACT_H && synced_n;
    cur_hit = cur_vis && cx_n == cursor_x && cy_n == cursor_y && (ly_n == 5'd14 || ly_n == 5'd15);
  end
`ifdef VGA_TEXT_CURSOR_EN
  logic [4:0] frames;
  logic vb_q;
  always_ff @(posedge clk36m or negedge reset_n)
    if (!reset_n) begin
      frames <= '0;
      vb_q <= 1'b0;
    end else begin
      vb_q <= vblank_in;
      if (vblank_in && !vb_q) frames <= frames + 5'd1;
    end
  assign cur_vis = !frames[4];
`else
  assign cur_vis = 1'b0;
`endif
  // Glyph bit only exists inside the 8x16 part of the 10x20 cell; padding shows background.
  assign glyph = s4[9:6] < 4'd8 && s4[5:1] < 5'd16 ? font_data[3'd7 - s4[8:6]] : 1'b0;
  assign pix = s4[10] && (glyph ^ inv4 ^ s4[0]) && !dly[3][1] && !dly[3][0];
  always_ff @(posedge clk36m or negedge reset_n)
    if (!reset_n) begin
      px <= '0;
      cx <= '0;
      ly <= '0;
      cy <= '0;
      line_base <= '0;
      synced <= 1'b0;
      vram_addr <= '0;
      font_addr <= '0;
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
      s4 <= '0;
      inv3 <= 1'b0;
      inv4 <= 1'b0;
      dly <= '0;
      rgb <= '0;
    end else begin
      px <= px_n;
      cx <= cx_n;
      ly <= ly_n;
      cy <= cy_n;
      line_base <= line_base_n;
      synced <= synced_n;
      if (active) vram_addr <= line_base_n + {5'd0, cx_n};
      s1 <= {active, px_n, ly_n, cur_hit};
      s2 <= s1;
      if (s2[10]) font_addr <= {vram_data[6:0], s2[4:1]};
      s3 <= s2;
      inv3 <= vram_data[7];
      s4 <= s3;
      inv4 <= inv3;
      dly <= {dly[3:0], {hsync_in, vsync_in, hblank_in, vblank_in}};
      rgb <= pix ? FG_RGB : 18'd0;
    end
  assign {video_r, video_g, video_b} = rgb;
  assign {hsync, vsync, hblank, vblank} = dly[4];
endmodule

// File: doc/vga_text_renderer.md
Name: vga_text_renderer

Overview:
- Text-mode pixel generator sitting directly downstream of the 800x600 VGA timing generator (clk36m domain, 1024 cols x 625 rows per frame).
- Consumes the col/row counters and the sync/blank strobes. Renders an 80x30 character screen from video RAM through an 8x16 font ROM.
- Produces monochrome-as-colour RGB with sync/blank re-aligned to the pixel pipeline.

Parameters:
- FG_RGB, 18'h00FC0, foreground colour {r[5:0],g[5:0],b[5:0]}; background is always 0.
- TEXT_COLS, 80, characters per line (cell width 10 px; 80*10 = 800).
- TEXT_ROWS, 30, character lines (cell height 20 lines; 30*20 = 600).

Ports:
- clk36m  in  1  pixel clock
- reset_n  in  1  asynchronous, active-low reset
- col  in  11  horizontal counter from timing generator, 0..1023
- row  in  10  vertical counter from timing generator, 0..624
- hsync_in  in  1  timing-generator hsync
- vsync_in  in  1  timing-generator vsync
- hblank_in  in  1  timing-generator hblank
- vblank_in  in  1  timing-generator vblank
- vram_addr  out  12  video RAM read address, cy*80+cx
- vram_data  in  8  [6:0] char code, [7] inverse attribute; valid one cycle after vram_addr
- font_addr  out  11  {char[6:0], glyph line[3:0]}
- font_data  in  8  glyph row, bit 7 = leftmost pixel; valid one cycle after font_addr
- cursor_x  in  7  cursor column (used only with CURSOR_EN)
- cursor_y  in  5  cursor line (used only with CURSOR_EN)
- video_r / video_g / video_b  out  6 each  pixel colour
- hsync / vsync / hblank / vblank  out  1 each  strobes delayed to match pixel

Behaviour:
- Reset (asynchronous, reset_n = 0): all outputs 0; counters px, cx, ly, cy, line_base = 0; pipeline registers 0; synced = 0.
- Horizontal tracking, each cycle:
  - col == 0: px = 0, cx = 0.
  - Otherwise, if px == 9: px = 0, cx++.
  - Otherwise: px++.
- Vertical tracking, only when col == 0:
  - row == 0: ly = 0, cy = 0, line_base = 0, synced = 1.
  - Otherwise, if ly == 19: ly = 0, cy++, line_base += 80.
  - Otherwise: ly++.
- No division or multiplication; vram_addr = line_base + cx, computed in 12 bits.
- Active area: col < 800 and row < 600 and synced. Outside the active area:
  - vram_addr and font_addr hold their last value.
  - Pixel is forced to 0.
- Pipeline (latency 5 cycles, col/row sampled in cycle 0):
  - Cycle 1: vram_addr registered.
  - Cycle 2: vram_data valid.
  - Cycle 3: font_addr registered, together with inverse bit, px and ly.
  - Cycle 4: font_data valid.
  - Cycle 5: RGB registered.
- Pixel value: glyph bit = font_data[7-px] when px < 8 and ly < 16, else 0. Pixel = glyph bit XOR inverse. Padding columns (px 8,9) and padding lines (ly 16..19) therefore show the inverse background.
- Output colour:
  - video_* = FG_RGB fields when pixel = 1 and delayed hblank/vblank are both 0.
  - video_* = 0 otherwise.
- hsync, vsync, hblank, vblank: each is its input delayed by exactly 5 cycles. Any input skew is preserved unchanged.
- Reset mid-frame: synced = 0 and RGB = 0 until the first col == 0 && row == 0. Delayed sync strobes resume after 5 cycles regardless of synced.
- Char code bit 7 is never used for the font address; font_addr[10:4] = vram_data[6:0].

Optional Feature:
- Macro: VGA_TEXT_CURSOR_EN.
- Defined:
  - A 5-bit frame counter increments on each vblank_in rising edge; reset value 0.
  - The cursor is visible while counter[4] == 0 (about 1.8 Hz blink).
  - In the cell where cx == cursor_x and cy == cursor_y, glyph lines ly 14 and 15 (all 10 px) are XOR-inverted while the cursor is visible.
  - The cursor test is pipelined so pixel latency stays 5.
- Undefined: cursor_x and cursor_y are ignored, no frame counter exists, output is identical to the defined case with the cursor invisible.

Test Plan:
- Reset release, then first frame: RGB = 0 for all cycles before col = 0/row = 0 → sync seen → active pixels appear 5 cycles after the corresponding col; hsync output rises 5 cycles after hsync_in.
- VRAM all 0x41, font 'A' line 0 = 8'h18: row 0 shows cols 3,4 at FG = 00/3F/00; cols 8,9 = 0; pattern repeats every 10 px.
- Char 0xC1 at address 0: cell 0 inverted → cols 0..2, 5..9 foreground on row 0; rows 16..19 of cell fully foreground.
- vram_addr check: col = 5, row = 45 → vram_addr = 2*80 + 0 = 160 in cycle 1; col = 795, row = 599 → vram_addr = 29*80 + 79 = 2399.
- Blanking boundary: col 800..1023 and row 600..624 → vram_addr held, RGB = 0 even with glyph data 8'hFF.
- VGA_TEXT_CURSOR_EN, cursor (10,3): rows 74,75 (ly 14,15), cols 100..109 inverted during frames 0..15; not inverted during frames 16..31.
